r4_butter_pipe: RTL and testbench

R4_BUTTER_PIPE -- requirements
Module: r4_butter_pipe

---
 rtl/r4_butter_pipe.sv | 119 +++++++++++
 tb/tb_r4_butter_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/r4_butter_pipe.sv
// Two-stage pipelined radix-4 DFT butterfly with valid/ready flow control.
// Optional accepted-output counter enabled by defining R4BF_CNT_EN.
module r4_butter_pipe #(
  parameter  int unsigned W  = 8,
  localparam int unsigned OW = W + 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            inv_i,
  input  logic [4*W-1:0]  xr_i,
  input  logic [4*W-1:0]  xi_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*OW-1:0] Xr_o,
  output logic [4*OW-1:0] Xi_o
`ifdef R4BF_CNT_EN
  ,
  output logic [15:0]     out_cnt_o
`endif
);

  localparam int unsigned W1 = W + 1;

  logic signed [W-1:0]  ar [4];
  logic signed [W-1:0]  ai [4];
  logic signed [W1-1:0] p_r, p_i, q_r, q_i, r_r, r_i, s_r, s_i;
  logic signed [W1-1:0] p_r_n, p_i_n, q_r_n, q_i_n, r_r_n, r_i_n, s_r_n, s_i_n;
  logic                 v1;
  logic                 inv1;
  logic                 adv1, adv2;
  logic signed [OW-1:0] x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;

  // Stage advance: a stage moves when it is empty or its successor moves.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  // Unpack lanes a,b,c,d and form the stage-1 sums/differences at W+1 bits.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ar[k] = xr_i[k*W +: W];
      ai[k] = xi_i[k*W +: W];
    end
    p_r_n = W1'(ar[0]) + W1'(ar[2]);
    p_i_n = W1'(ai[0]) + W1'(ai[2]);
    q_r_n = W1'(ar[0]) - W1'(ar[2]);
    q_i_n = W1'(ai[0]) - W1'(ai[2]);
    r_r_n = W1'(ar[1]) + W1'(ar[3]);
    r_i_n = W1'(ai[1]) + W1'(ai[3]);
    s_r_n = W1'(ar[1]) - W1'(ar[3]);
    s_i_n = W1'(ai[1]) - W1'(ai[3]);
  end

  // Stage-1 register: partial sums travel together with their inverse flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      v1   <= 1'b0;
      inv1 <= 1'b0;
      p_r  <= '0;
      p_i  <= '0;
      q_r  <= '0;
      q_i  <= '0;
      r_r  <= '0;
      r_i  <= '0;
      s_r  <= '0;
      s_i  <= '0;
    end else if (adv1) begin
      v1   <= in_valid;
      inv1 <= inv_i;
      p_r  <= p_r_n;
      p_i  <= p_i_n;
      q_r  <= q_r_n;
      q_i  <= q_i_n;
      r_r  <= r_r_n;
      r_i  <= r_i_n;
      s_r  <= s_r_n;
      s_i  <= s_i_n;
    end
  end

  // Stage-2 combine; -j*s = (s_i, -s_r), and inverse mode swaps the X1/X3 rotations.
  always_comb begin
    x0r = OW'(p_r) + OW'(r_r);
    x0i = OW'(p_i) + OW'(r_i);
    x2r = OW'(p_r) - OW'(r_r);
    x2i = OW'(p_i) - OW'(r_i);
    x1r = inv1 ? OW'(q_r) - OW'(s_i) : OW'(q_r) + OW'(s_i);
    x1i = inv1 ? OW'(q_i) + OW'(s_r) : OW'(q_i) - OW'(s_r);
    x3r = inv1 ? OW'(q_r) + OW'(s_i) : OW'(q_r) - OW'(s_i);
    x3i = inv1 ? OW'(q_i) - OW'(s_r) : OW'(q_i) + OW'(s_r);
  end

  // Stage-2 register drives the outputs directly; holds while stalled.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_valid <= 1'b0;
      Xr_o      <= '0;
      Xi_o      <= '0;
    end else if (adv2) begin
      out_valid <= v1;
      Xr_o      <= {x3r, x2r, x1r, x0r};
      Xi_o      <= {x3i, x2i, x1i, x0i};
    end
  end

`ifdef R4BF_CNT_EN
  // Saturating count of output transfers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_cnt_o <= '0;
    end else if (out_valid && out_ready && (out_cnt_o != 16'hFFFF)) begin
      out_cnt_o <= out_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_r4_butter_pipe.sv
// Directed self-checking bench for r4_butter_pipe (W=8); counter test runs when R4BF_CNT_EN is defined.
module tb_r4_butter_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = W + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            inv_i = 1'b0;
  logic [4*W-1:0]  xr_i = '0;
  logic [4*W-1:0]  xi_i = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [4*OW-1:0] Xr_o;
  logic [4*OW-1:0] Xi_o;
`ifdef R4BF_CNT_EN
  logic [15:0]     out_cnt;
`endif

  int n_chk = 0;
  int n_bad = 0;

  r4_butter_pipe #(.W(W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inv_i     (inv_i),
    .xr_i      (xr_i),
    .xi_i      (xi_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Xr_o      (Xr_o),
    .Xi_o      (Xi_o)
`ifdef R4BF_CNT_EN
    ,
    .out_cnt_o (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Directed vectors, lanes ordered a,b,c,d / X0..X3; expectations worked out by hand.
  int v_ar [7][4] = '{'{10,0,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{-128,-128,-128,-128},
                      '{127,127,127,127}, '{1,3,5,7}, '{1,3,5,7}};
  int v_ai [7][4] = '{'{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{-128,-128,-128,-128},
                      '{127,127,127,127}, '{2,4,6,8}, '{2,4,6,8}};
  bit v_inv [7]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int v_er [7][4] = '{'{10,10,10,10}, '{1,0,-1,0}, '{1,0,-1,0}, '{-512,0,0,0},
                      '{508,0,0,0}, '{16,-8,-4,0}, '{16,0,-4,-8}};
  int v_ei [7][4] = '{'{0,0,0,0}, '{0,-1,0,1}, '{0,1,0,-1}, '{-512,0,0,0},
                      '{508,0,0,0}, '{20,0,-4,-8}, '{20,-8,-4,0}};

  function automatic logic [4*W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [4*W-1:0] v;
    v[0*W +: W] = W'(l0);
    v[1*W +: W] = W'(l1);
    v[2*W +: W] = W'(l2);
    v[3*W +: W] = W'(l3);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_chk++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_chk++;
    if (Xr_o !== '0 || Xi_o !== '0) begin
      n_bad++; $display("FAIL reset data: got %h/%h want 0", Xr_o, Xi_o);
    end
`ifdef R4BF_CNT_EN
    n_chk++;
    if (out_cnt !== 16'd0) begin n_bad++; $display("FAIL reset cnt: got %0d want 0", out_cnt); end
`endif
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      inv_i    = v_inv[i];
      xr_i     = pack4(v_ar[i][0], v_ar[i][1], v_ar[i][2], v_ar[i][3]);
      xi_i     = pack4(v_ai[i][0], v_ai[i][1], v_ai[i][2], v_ai[i][3]);
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL vec%0d in_ready: got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      inv_i    = ~inv_i;
      tick();
      n_chk++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL vec%0d latency: out_valid %b want 1", i, out_valid); end
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (Xr_o[k*OW +: OW] !== OW'(v_er[i][k]) || Xi_o[k*OW +: OW] !== OW'(v_ei[i][k])) begin
          n_bad++;
          $display("FAIL vec%0d X%0d: got (%0d,%0d) want (%0d,%0d)", i, k,
                   $signed(Xr_o[k*OW +: OW]), $signed(Xi_o[k*OW +: OW]), v_er[i][k], v_ei[i][k]);
        end
      end
    end
    repeat (2) tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vec drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int del = 0;
    logic            stalled_prev = 1'b0;
    logic            hv = 1'b0;
    logic [4*OW-1:0] hr = '0;
    logic [4*OW-1:0] hi = '0;
    logic            exp_rdy;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c < 7);
      in_valid  = (acc < 5);
      if (acc < 5) begin
        xr_i  = pack4((acc + 1) * 10, 0, 0, 0);
        xi_i  = pack4(-(acc + 1), 0, 0, 0);
        inv_i = 1'(acc % 2);
      end
      @(negedge clk);
      exp_rdy = ((acc - del) < 2) || out_ready;
      n_chk++;
      if (in_ready !== exp_rdy) begin
        n_bad++; $display("FAIL b2b c%0d in_ready: got %b want %b", c, in_ready, exp_rdy);
      end
      if (stalled_prev) begin
        n_chk++;
        if (out_valid !== hv || Xr_o !== hr || Xi_o !== hi) begin
          n_bad++; $display("FAIL b2b c%0d hold: got %b %h %h want %b %h %h", c, out_valid, Xr_o, Xi_o, hv, hr, hi);
        end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (del >= 5) begin
          n_bad++; $display("FAIL b2b c%0d extra output: got %h want none", c, Xr_o);
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (Xr_o[k*OW +: OW] !== OW'((del + 1) * 10) || Xi_o[k*OW +: OW] !== OW'(-(del + 1))) begin
              n_bad++;
              $display("FAIL b2b set%0d X%0d: got (%0d,%0d) want (%0d,%0d)", del, k,
                       $signed(Xr_o[k*OW +: OW]), $signed(Xi_o[k*OW +: OW]), (del + 1) * 10, -(del + 1));
              break;
            end
          end
          del++;
        end
      end
      stalled_prev = out_valid && !out_ready;
      hv = out_valid;
      hr = Xr_o;
      hi = Xi_o;
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (acc != 5 || del != 5) begin
      n_bad++; $display("FAIL b2b counts: got acc=%0d del=%0d want 5/5", acc, del);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    inv_i     = 1'b0;
    in_valid  = 1'b1;
    xr_i      = pack4(77, 0, 0, 0);
    xi_i      = '0;
    tick();
    xr_i      = pack4(88, 0, 0, 0);
    tick();
    in_valid  = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst pre: out_valid %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst async: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
    end
    n_chk++;
    if (Xr_o !== '0) begin n_bad++; $display("FAIL midrst data: got %h want 0", Xr_o); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst stale c%0d: out_valid %b want 0", c, out_valid); end
    end
    in_valid = 1'b1;
    xr_i     = pack4(3, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst early: out_valid %b want 0", out_valid); end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || Xr_o[2*OW +: OW] !== OW'(3) || Xr_o[0 +: OW] !== OW'(3)) begin
      n_bad++; $display("FAIL midrst post: out_valid %b X0r %0d want 1/3", out_valid, $signed(Xr_o[0 +: OW]));
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst dup: out_valid %b want 0", out_valid); end
  endtask

`ifdef R4BF_CNT_EN
  task automatic test_counter();
    apply_reset();
    n_chk++;
    if (out_cnt !== 16'd0) begin n_bad++; $display("FAIL cnt clear: got %0d want 0", out_cnt); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    xr_i      = pack4(1, 0, 0, 0);
    xi_i      = '0;
    repeat (1000) @(posedge clk);
    #1;
    n_chk++;
    if (out_cnt !== 16'd998) begin n_bad++; $display("FAIL cnt 1000: got %0d want 998", out_cnt); end
    repeat (64536) @(posedge clk);
    #1;
    n_chk++;
    if (out_cnt !== 16'hFFFE) begin n_bad++; $display("FAIL cnt 65536: got %h want fffe", out_cnt); end
    repeat (4464) @(posedge clk);
    #1;
    n_chk++;
    if (out_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL cnt sat: got %h want ffff", out_cnt); end
    repeat (100) @(posedge clk);
    #1;
    n_chk++;
    if (out_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL cnt hold: got %h want ffff", out_cnt); end
    in_valid = 1'b0;
    repeat (2) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midflight();
`ifdef R4BF_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
